// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle control for the MIPS datapath. Issues one-hot
// stage tokens fetch..write-back, owns the program counter, applies branch
// redirects at retire, halts on endProgram and guards each stage with a
// watchdog.
module stage_sequencer #(
   parameter int PC_WIDTH      = 4,
   parameter int STAGE_TIMEOUT = 15
) (
   input  logic                       clock,
   input  logic                       start,
   input  logic                       run,
   input  logic [4:0]                 done,
   input  logic                       branch,
   input  logic                       zero,
   input  logic signed [PC_WIDTH-1:0] branchOffset,
   input  logic                       endProgram,
   output logic                       stage1,
   output logic                       stage2,
   output logic                       stage3,
   output logic                       stage4,
   output logic                       stage5,
   output logic [PC_WIDTH-1:0]        pc,
   output logic                       halted,
   output logic                       timeoutErr,
   output logic [15:0]                instrCount
);

   typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, HALT} state_t;

   localparam logic [7:0] WD_LAST = 8'(STAGE_TIMEOUT - 1);

   state_t                     state;
   state_t                     nxt;
   logic [7:0]                 wd_cnt;
   logic                       take;
   logic signed [PC_WIDTH-1:0] offset;
   logic                       in_stage;
   logic                       stage_done;
   logic                       retire;
   logic                       latch_alu;
   logic                       go_halt;
   logic                       go_tmo;

   // Retire address: sequential successor plus the latched branch offset.
   // Sign extension is moot because the sum is truncated to PC_WIDTH.
   function automatic logic [PC_WIDTH-1:0] next_pc(
      input logic [PC_WIDTH-1:0]        cur,
      input logic                       tk,
      input logic signed [PC_WIDTH-1:0] off
   );
      logic [PC_WIDTH-1:0] step;
      step = tk ? $unsigned(off) : '0;
      return cur + PC_WIDTH'(1) + step;
   endfunction

   // Retired-instruction counter sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // State register; reset overrides everything.
   always_ff @(posedge clock) begin
      if (start) state <= IDLE;
      else       state <= nxt;
   end

   // Next-state logic and one-cycle control strobes for the datapath.
   always_comb begin
      nxt        = state;
      retire     = 1'b0;
      latch_alu  = 1'b0;
      go_halt    = 1'b0;
      go_tmo     = 1'b0;
      in_stage   = 1'b1;
      stage_done = 1'b0;
      case (state)
         S1:      stage_done = done[0];
         S2:      stage_done = done[1];
         S3:      stage_done = done[2];
         S4:      stage_done = done[3];
         S5:      stage_done = done[4];
         default: in_stage   = 1'b0;
      endcase
      case (state)
         IDLE: if (run) nxt = S1;
         S1:   if (stage_done) nxt = S2;
         S2: begin
            if (stage_done) begin
               if (endProgram) begin
                  nxt     = HALT;
                  go_halt = 1'b1;
               end else begin
                  nxt = S3;
               end
            end
         end
         S3: begin
            if (stage_done) begin
               latch_alu = 1'b1;
               nxt       = S4;
            end
         end
         S4:   if (stage_done) nxt = S5;
         S5: begin
            if (stage_done) begin
               retire = 1'b1;
               nxt    = run ? S1 : IDLE;
            end
         end
         HALT: nxt = HALT;
         default: nxt = IDLE;
      endcase
      // A done in the last allowed cycle still wins over the watchdog.
      if (in_stage && !stage_done && (wd_cnt == WD_LAST)) begin
         nxt     = HALT;
         go_halt = 1'b1;
         go_tmo  = 1'b1;
      end
   end

   // Registered one-hot tokens, decoded from the upcoming state.
   always_ff @(posedge clock) begin
      if (start) begin
         {stage5, stage4, stage3, stage2, stage1} <= '0;
      end else begin
         stage1 <= (nxt == S1);
         stage2 <= (nxt == S2);
         stage3 <= (nxt == S3);
         stage4 <= (nxt == S4);
         stage5 <= (nxt == S5);
      end
   end

   // Watchdog: zero on every state entry, counts cycles spent in a stage.
   always_ff @(posedge clock) begin
      if (start || (nxt != state) || !in_stage) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + 8'd1;
   end

   // Architectural state: branch latch, pc, retire count and sticky flags.
   always_ff @(posedge clock) begin
      if (start) begin
         take       <= 1'b0;
         offset     <= '0;
         pc         <= '0;
         instrCount <= '0;
         halted     <= 1'b0;
         timeoutErr <= 1'b0;
      end else begin
         if (latch_alu) begin
            take   <= branch & zero;
            offset <= branchOffset;
         end
         if (retire) begin
            pc         <= next_pc(pc, take, offset);
            instrCount <= sat_inc(instrCount);
            take       <= 1'b0;
         end
         if (go_halt) halted     <= 1'b1;
         if (go_tmo)  timeoutErr <= 1'b1;
      end
   end

endmodule
